// File: rtl/regfile_sb_if.sv
// Bundle of the write-back, decode-read and scoreboard-mark signals that
// connect the pipeline to the register file.
interface regfile_sb_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
);
    logic              w_enable_i;
    logic [ADDR_W-1:0] w_addr_i;
    logic [DATA_W-1:0] w_data_i;
    logic              r1_enable_i;
    logic [ADDR_W-1:0] r1_addr_i;
    logic [DATA_W-1:0] r1_data_o;
    logic              r2_enable_i;
    logic [ADDR_W-1:0] r2_addr_i;
    logic [DATA_W-1:0] r2_data_o;
    logic              mark_enable_i;
    logic [ADDR_W-1:0] mark_addr_i;
    logic [REG_NUM-1:0] busy_o;
    logic              stall_o;

    modport master (
        output w_enable_i, w_addr_i, w_data_i,
        output r1_enable_i, r1_addr_i, r2_enable_i, r2_addr_i,
        output mark_enable_i, mark_addr_i,
        input  r1_data_o, r2_data_o, busy_o, stall_o
    );

    modport slave (
        input  w_enable_i, w_addr_i, w_data_i,
        input  r1_enable_i, r1_addr_i, r2_enable_i, r2_addr_i,
        input  mark_enable_i, mark_addr_i,
        output r1_data_o, r2_data_o, busy_o, stall_o
    );
endinterface

// File: rtl/regfile_sb.sv
// 32-entry register file with two bypassed read ports, one write port and a
// per-register busy scoreboard that stalls decode on unresolved load results.
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  rf
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    logic [DATA_W-1:0]  regs_r [REG_NUM];
    logic [REG_NUM-1:0] busy_r;
    logic [REG_NUM-1:0] busy_nxt_s;
    logic               wr_hit_s;
    logic [DATA_W-1:0]  r1_data_s;
    logic [DATA_W-1:0]  r2_data_s;
    logic               r1_stall_s;
    logic               r2_stall_s;

    assign wr_hit_s = rf.w_enable_i && (rf.w_addr_i != ZERO_ADDR);

    // Register array: x0 is never written, so it stays at reset zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (wr_hit_s) begin
            regs_r[rf.w_addr_i] <= rf.w_data_i;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Next busy vector: a new mark outranks a retiring write to the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 1; i < REG_NUM; i++) begin
            if (rf.mark_enable_i && (rf.mark_addr_i == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_hit_s && (rf.w_addr_i == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {REG_NUM{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Read port 1 with same-cycle write bypass.
    always_comb begin
        r1_data_s = ZERO_DATA;
        if (rst || !rf.r1_enable_i || (rf.r1_addr_i == ZERO_ADDR)) begin
            r1_data_s = ZERO_DATA;
        end else if (rf.w_enable_i && (rf.w_addr_i == rf.r1_addr_i)) begin
            r1_data_s = rf.w_data_i;
        end else begin
            r1_data_s = regs_r[rf.r1_addr_i];
        end
    end

    // Read port 2 with same-cycle write bypass.
    always_comb begin
        r2_data_s = ZERO_DATA;
        if (rst || !rf.r2_enable_i || (rf.r2_addr_i == ZERO_ADDR)) begin
            r2_data_s = ZERO_DATA;
        end else if (rf.w_enable_i && (rf.w_addr_i == rf.r2_addr_i)) begin
            r2_data_s = rf.w_data_i;
        end else begin
            r2_data_s = regs_r[rf.r2_addr_i];
        end
    end

    // A busy operand being written back this cycle is covered by the bypass.
    assign r1_stall_s = rf.r1_enable_i && (rf.r1_addr_i != ZERO_ADDR) && busy_r[rf.r1_addr_i]
                        && !(rf.w_enable_i && (rf.w_addr_i == rf.r1_addr_i));
    assign r2_stall_s = rf.r2_enable_i && (rf.r2_addr_i != ZERO_ADDR) && busy_r[rf.r2_addr_i]
                        && !(rf.w_enable_i && (rf.w_addr_i == rf.r2_addr_i));

    assign rf.r1_data_o = r1_data_s;
    assign rf.r2_data_o = r2_data_s;
    assign rf.stall_o   = r1_stall_s || r2_stall_s;
    assign rf.busy_o    = busy_r;

endmodule
